// File: rtl/seg_frame_buffer.sv
// Eight-digit active-low segment frame buffer feeding the multiplexed 7-segment scanner.
// Host writes (raw or hex-decoded), tick-driven ring rotation, per-digit blink, 1-cycle read.
module seg_frame_buffer #(
  parameter int TICK_DIV = 12500000,
  parameter int CNT_W    = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic       wr_mode,
  input  logic [7:0] wr_data,
  input  logic       anim_en,
  input  logic [7:0] dir_mask,
  input  logic [7:0] blink_mask,
  input  logic [2:0] scan_idx,
  output logic [7:0] seg_data,
  output logic       tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             blink_phase_r;
  logic [7:0]       buf_r [8];
  logic [7:0]       seg_data_r;
  logic             tick_s;
  logic             rot_s;
  logic             wr_fire_s;
  logic [7:0]       wr_value_s;

  // Hex nibble to active-low segments a..g (dp handled separately).
  function automatic logic [6:0] hex_dec(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Ring-rotate the six outer segments a..f; g and dp stay put.
  function automatic logic [7:0] ring_rot(input logic [7:0] b, input logic left);
    logic [7:0] r;
    if (left) begin
      r = {b[7:6], b[4:0], b[5]};
    end else begin
      r = {b[7:6], b[0], b[5:1]};
    end
    return r;
  endfunction

  assign tick_s    = (cnt_r == CNT_LAST);
  assign rot_s     = tick_s & anim_en;
  assign wr_fire_s = wr_valid & ~rot_s;
  assign wr_ready  = ~rot_s;
  assign tick      = tick_s;
  assign seg_data  = seg_data_r;

  // Value stored by an accepted write.
  always_comb begin
    wr_value_s = wr_data;
    if (wr_mode) begin
      wr_value_s = {~wr_data[7], hex_dec(wr_data[3:0])};
    end else begin
      wr_value_s = wr_data;
    end
  end

  // Free-running tick divider and blink phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r         <= {CNT_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (tick_s) begin
      cnt_r         <= {CNT_W{1'b0}};
      blink_phase_r <= ~blink_phase_r;
    end else begin
      cnt_r         <= cnt_r + CNT_W'(1);
      blink_phase_r <= blink_phase_r;
    end
  end

  // Frame buffer: writes never coincide with a rotation because wr_ready drops then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        buf_r[i] <= 8'hFF;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_fire_s && (wr_addr == 3'(i))) begin
          buf_r[i] <= wr_value_s;
        end else if (rot_s) begin
          buf_r[i] <= ring_rot(buf_r[i], dir_mask[i]);
        end else begin
          buf_r[i] <= buf_r[i];
        end
      end
    end
  end

  // Registered scanner read, blanked during the blink-off phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_data_r <= 8'hFF;
    end else if (blink_mask[scan_idx] && blink_phase_r) begin
      seg_data_r <= 8'hFF;
    end else begin
      seg_data_r <= buf_r[scan_idx];
    end
  end

endmodule

// File: tb/tb_seg_frame_buffer.sv
// Directed self-checking bench for seg_frame_buffer with TICK_DIV=4.
module tb_seg_frame_buffer;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic       wr_mode;
  logic [7:0] wr_data;
  logic       anim_en;
  logic [7:0] dir_mask;
  logic [7:0] blink_mask;
  logic [2:0] scan_idx;
  logic [7:0] seg_data;
  logic       tick;

  int n_vec;
  int n_err;

  int   m_cnt;
  logic m_phase;

  seg_frame_buffer #(.TICK_DIV(TD), .CNT_W(24)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_mode(wr_mode), .wr_data(wr_data), .anim_en(anim_en),
    .dir_mask(dir_mask), .blink_mask(blink_mask), .scan_idx(scan_idx),
    .seg_data(seg_data), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent blink-phase reference built from its own divider.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt   <= 0;
      m_phase <= 1'b0;
    end else if (m_cnt == TD - 1) begin
      m_cnt   <= 0;
      m_phase <= ~m_phase;
    end else begin
      m_cnt   <= m_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic m, input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    wr_valid = 1'b1; wr_addr = a; wr_mode = m; wr_data = d;
    for (int i = 0; i < 4; i++) begin
      #1;
      acc = wr_ready;
      step();
      if (acc) break;
    end
    wr_valid = 1'b0;
    n_vec++;
    if (acc !== 1'b1) begin
      $display("FAIL write_accept: got %b want 1", acc);
      n_err++;
    end
  endtask

  task automatic read_check(input string nm, input logic [2:0] idx, input logic [7:0] exp);
    scan_idx = idx;
    step();
    n_vec++;
    if (seg_data !== exp) begin
      $display("FAIL %s: idx %0d got %h want %h", nm, idx, seg_data, exp);
      n_err++;
    end
  endtask

  task automatic wait_tick();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) begin
      n_vec++;
      $display("FAIL tick_timeout: got no tick want tick within 8 cycles");
      n_err++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_t;
    exp_t = 4'b1000;
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (tick !== exp_t[k]) begin
        $display("FAIL reset_tick: cycle %0d got %b want %b", k, tick, exp_t[k]);
        n_err++;
      end
      if (k < 3) step();
    end
    n_vec++;
    if (wr_ready !== 1'b1) begin
      $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
      n_err++;
    end
    for (int i = 0; i < 8; i++) read_check("reset_blank", 3'(i), 8'hFF);
  endtask

  task automatic test_hex_write();
    do_write(3'd2, 1'b1, 8'h85);
    read_check("hex_5_dp", 3'd2, 8'h12);
    do_write(3'd5, 1'b1, 8'h7B);
    read_check("hex_b_ignored_bits", 3'd5, 8'h83);
  endtask

  task automatic test_same_addr();
    wr_valid = 1'b1; wr_addr = 3'd7; wr_mode = 1'b0; wr_data = 8'hA5; scan_idx = 3'd7;
    step();
    wr_valid = 1'b0;
    n_vec++;
    if (seg_data !== 8'hFF) begin
      $display("FAIL same_addr_old: got %h want ff", seg_data);
      n_err++;
    end
    read_check("same_addr_new", 3'd7, 8'hA5);
  endtask

  task automatic rotate_seq(input string nm, input logic [2:0] a, input logic [7:0] d,
                            input logic [7:0] dm, input logic [47:0] exp);
    do_write(a, 1'b0, d);
    dir_mask = dm;
    scan_idx = a;
    anim_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_tick();
      step();
      step();
      n_vec++;
      if (seg_data !== exp[47 - 8*k -: 8]) begin
        $display("FAIL %s: step %0d got %h want %h", nm, k, seg_data, exp[47 - 8*k -: 8]);
        n_err++;
      end
    end
    anim_en = 1'b0;
  endtask

  task automatic test_rotate_left();
    rotate_seq("rot_left", 3'd0, 8'hFE, 8'h01, 48'hFD_FB_F7_EF_DF_FE);
  endtask

  task automatic test_rotate_right();
    rotate_seq("rot_right", 3'd1, 8'hDF, 8'h00, 48'hEF_F7_FB_FD_FE_DF);
  endtask

  task automatic test_stall();
    dir_mask = 8'h00;
    anim_en = 1'b1;
    wait_tick();
    wr_valid = 1'b1; wr_addr = 3'd4; wr_mode = 1'b0; wr_data = 8'hC3;
    #1;
    n_vec++;
    if (wr_ready !== 1'b0) begin
      $display("FAIL stall_ready_low: got %b want 0", wr_ready);
      n_err++;
    end
    step();
    n_vec++;
    if (wr_ready !== 1'b1) begin
      $display("FAIL stall_ready_back: got %b want 1", wr_ready);
      n_err++;
    end
    step();
    wr_valid = 1'b0;
    anim_en = 1'b0;
    read_check("stall_not_rotated", 3'd4, 8'hC3);
  endtask

  task automatic test_tick_no_anim();
    anim_en = 1'b0;
    wait_tick();
    n_vec++;
    if (wr_ready !== 1'b1) begin
      $display("FAIL tick_no_anim_ready: got %b want 1", wr_ready);
      n_err++;
    end
    do_write(3'd5, 1'b0, 8'h5A);
    read_check("tick_no_anim_write", 3'd5, 8'h5A);
  endtask

  task automatic test_blink();
    do_write(3'd3, 1'b1, 8'h00);
    do_write(3'd6, 1'b0, 8'h3C);
    blink_mask = 8'h08;
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      step();
      read_check("blink_idx3", 3'd3, m_phase ? 8'hFF : 8'hC0);
      read_check("blink_idx6_steady", 3'd6, 8'h3C);
    end
    blink_mask = 8'h00;
  endtask

  task automatic test_reset_mid();
    anim_en = 1'b1;
    dir_mask = 8'hF0;
    scan_idx = 3'd6;
    repeat (5) step();
    reset = 1'b0;
    #1;
    n_vec++;
    if (seg_data !== 8'hFF || tick !== 1'b0) begin
      $display("FAIL mid_reset_async: got seg %h tick %b want ff 0", seg_data, tick);
      n_err++;
    end
    anim_en = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) read_check("mid_reset_blank", 3'(i), 8'hFF);
    n_vec++;
    if (tick !== 1'b0) begin
      $display("FAIL mid_reset_tick_early: got %b want 0", tick);
      n_err++;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0; wr_valid = 1'b0; wr_addr = 3'd0; wr_mode = 1'b0; wr_data = 8'h00;
    anim_en = 1'b0; dir_mask = 8'h00; blink_mask = 8'h00; scan_idx = 3'd0;
    test_reset();
    test_hex_write();
    test_same_addr();
    test_rotate_left();
    test_rotate_right();
    test_stall();
    test_tick_no_anim();
    test_blink();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
